swap_datapath: RTL
==================

SWAP_DATAPATH -- requirements
Module: swap_datapath

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width of each register.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 w  input  1  write-enable from the swap controller; 1 = swap step active.
REQ-005 sel  input  2  swap step select from the swap controller (1 = A->T, 2 = B->A, 3 = T->B, 0 = idle).
REQ-006 load  input  1  parallel-load request for A and B.
REQ-007 a_in, b_in  input  WIDTH each  load data for A and B.
REQ-008 err_clr  input  1  clears the sticky error flag.
REQ-009 a_out, b_out  output  WIDTH each  current contents of registers A and B.
REQ-010 busy  output  1  swap sequence in progress.
REQ-011 done  output  1  one-cycle pulse when a swap completes.
REQ-012 err  output  1  sticky protocol-violation flag.
REQ-013 swap_cnt  output  8  count of completed swaps, wrapping modulo 256.

Function
REQ-014 The block SHALL hold three registers: A, B and temp T, each WIDTH bits; a_out = A and b_out = B directly from registers.
REQ-015 The block SHALL track the expected step in a phase register: P0 (expect sel=1), P1 (expect sel=2), P2 (expect sel=3).
REQ-016 In P0 with w=1 and sel=1, the block SHALL write T<=A at that edge and go to P1.
REQ-017 In P1 with w=1 and sel=2, the block SHALL write A<=B and go to P2.
REQ-018 In P2 with w=1 and sel=3, the block SHALL write B<=T, go to P0, pulse done high for exactly the next cycle and increment swap_cnt.
REQ-019 With w=1, any sel value other than the expected one SHALL perform no register write, set err, and return phase to P0.
REQ-020 With w=0 in P0, sel SHALL be ignored, with no write and no error.
REQ-021 With w=0 in P1 or P2 (aborted sequence), the block SHALL set err and return to P0; A, B and T keep their partially swapped values.
REQ-022 busy SHALL be 1 exactly when phase is P1 or P2.
REQ-023 load=1 in P0 with w=0 SHALL write A<=a_in and B<=b_in at that edge; T is unchanged.
REQ-024 load=1 in the same cycle as w=1 or while busy=1 SHALL be ignored (no A/B load) and SHALL set err; the swap step in that cycle proceeds per REQ-016..021.
REQ-025 err_clr=1 SHALL clear err at the edge unless a new violation occurs in the same cycle, in which case err stays 1 (set wins).
REQ-026 swap_cnt SHALL wrap from 255 to 0 on the 256th completed swap without error.
REQ-027 All outputs SHALL be registered; latency from the sel=3 edge to done=1 is one cycle.

Reset
REQ-028 At a rising clk edge with reset=1: A, B and T SHALL be 0, phase P0, busy=0, done=0, err=0 and swap_cnt=0; reset overrides load, w and err_clr.
REQ-029 Reset asserted mid-sequence (P1/P2) SHALL abort with no write and no err; after reset the block accepts a fresh sel=1.

Verification
REQ-030 Load a_in=0x5A, b_in=0xC3, then w=1 with sel=1,2,3 on consecutive cycles -> a_out=0xC3, b_out=0x5A, done pulse of 1 cycle, swap_cnt=1, err=0.
REQ-031 After REQ-030, w=1 sel=1, then w=1 sel=3 -> no write on the sel=3 cycle, err=1, phase P0, A=0xC3, B=0x5A, T=0xC3, swap_cnt unchanged.
REQ-032 w=1 sel=1, w=1 sel=2, then w=0 -> err=1, busy=0, A=B=original B, no done.
REQ-033 load=1 with a_in=0x11 during busy=1 -> A/B not loaded with 0x11, err=1; err_clr=1 the next idle cycle -> err=0.
REQ-034 Run 256 back-to-back legal swaps -> swap_cnt returns to 0; A/B equal their initial values (even swap count).
REQ-035 Assert reset in P2 -> all outputs 0 on the next cycle; a subsequent sel=1,2,3 sequence completes normally.

Source files
------------

// File: rtl/swap_datapath.sv
// Three-register swap datapath (A, B, temp T) stepped by an external controller,
// with phase tracking, protocol-violation detection, done pulse and swap counter.
module swap_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             w,
  input  logic [1:0]       sel,
  input  logic             load,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [7:0]       swap_cnt
);

  typedef enum logic [1:0] {
    P0 = 2'd0,
    P1 = 2'd1,
    P2 = 2'd2
  } phase_t;

  phase_t           phase, phase_n;
  logic [WIDTH-1:0] a_q, b_q, t_q;
  logic [WIDTH-1:0] a_n, b_n, t_n;
  logic             viol;
  logic             finish;

  always_comb begin
    phase_n = phase;
    a_n     = a_q;
    b_n     = b_q;
    t_n     = t_q;
    viol    = 1'b0;
    finish  = 1'b0;

    if (w) begin
      unique case (phase)
        P0: begin
          if (sel == 2'd1) begin
            t_n     = a_q;
            phase_n = P1;
          end else begin
            viol    = 1'b1;
            phase_n = P0;
          end
        end
        P1: begin
          if (sel == 2'd2) begin
            a_n     = b_q;
            phase_n = P2;
          end else begin
            viol    = 1'b1;
            phase_n = P0;
          end
        end
        P2: begin
          if (sel == 2'd3) begin
            b_n     = t_q;
            finish  = 1'b1;
            phase_n = P0;
          end else begin
            viol    = 1'b1;
            phase_n = P0;
          end
        end
        default: phase_n = P0;
      endcase
    end else if (phase != P0) begin
      // Aborted sequence: keep the partially swapped registers as they are.
      viol    = 1'b1;
      phase_n = P0;
    end else if (load) begin
      a_n = a_in;
      b_n = b_in;
    end

    // A load that collides with a swap step or an in-flight sequence is dropped.
    if (load && (w || phase != P0)) begin
      viol = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase    <= P0;
      a_q      <= '0;
      b_q      <= '0;
      t_q      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      swap_cnt <= '0;
    end else begin
      phase <= phase_n;
      a_q   <= a_n;
      b_q   <= b_n;
      t_q   <= t_n;
      busy  <= (phase_n != P0);
      done  <= finish;
      if (viol) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
      if (finish) begin
        swap_cnt <= swap_cnt + 8'd1;
      end
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;

endmodule
